// File: rtl/mm_counter_core.sv
// mm_counter_core: 4-bit multi-mode counter with winner/loser tallies.
// Sequences the game PLAY -> OVER -> CLEAR -> PLAY.
// Optional macro MM_AUTO_RESTART_EN: when defined, OVER exits to CLEAR on its
// own once the hold time has elapsed. When undefined, OVER waits for init=1
// after the hold time before it clears.
module mm_counter_core #(
    parameter int WIDTH     = 4,
    parameter int TALLY_W   = 4,
    parameter int OVER_HOLD = 2
) (
    input  logic               dclk,
    input  logic               arstn,
    input  logic               init,
    input  logic [WIDTH-1:0]   init_value,
    input  logic               en,
    input  logic [1:0]         ctrl,
    output logic [WIDTH-1:0]   count,
    output logic [TALLY_W-1:0] W_count,
    output logic [TALLY_W-1:0] L_count,
    output logic               game_end
);

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_OVER  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam int HOLD_W = (OVER_HOLD > 1) ? $clog2(OVER_HOLD) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(OVER_HOLD - 1);
    localparam logic [WIDTH-1:0]   COUNT_INIT = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]   COUNT_MAX  = '1;
    localparam logic [TALLY_W-1:0] TMAX       = '1;

    state_t              state_reg, state_next;
    logic [WIDTH-1:0]    count_reg, count_next;
    logic [TALLY_W-1:0]  w_reg, w_next;
    logic [TALLY_W-1:0]  l_reg, l_next;
    logic                game_end_reg, game_end_next;
    logic [HOLD_W-1:0]   hold_reg, hold_next;

    // Candidate step results, one per ctrl encoding: +1, +2, -1, -2.
    logic [WIDTH-1:0]    step_cand [4];
    logic [WIDTH-1:0]    step_result;
    logic [TALLY_W-1:0]  w_inc;
    logic [TALLY_W-1:0]  l_inc;
    logic                hold_done;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_step
            if (gi < 2) begin : g_up
                assign step_cand[gi] = count_reg + WIDTH'(gi + 1);
            end else begin : g_dn
                assign step_cand[gi] = count_reg - WIDTH'(gi - 1);
            end
        end
    endgenerate

    assign step_result = step_cand[ctrl];
    assign w_inc       = w_reg + 1'b1;
    assign l_inc       = l_reg + 1'b1;
    // The OVER_HOLD-th OVER cycle is ending at this edge.
    assign hold_done   = (hold_reg == HOLD_LAST);

    // Next-state and next-value logic for counter, tallies and game sequencing.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        w_next     = w_reg;
        l_next     = l_reg;
        hold_next  = hold_reg;
        case (state_reg)
            ST_PLAY: begin
                if (init) begin
                    // Loads never score, even when loading 0 or all-ones.
                    count_next = init_value;
                end else if (en) begin
                    count_next = step_result;
                    if (step_result == COUNT_MAX) begin
                        w_next = w_inc;
                        if (w_inc == TMAX) begin
                            state_next = ST_OVER;
                            hold_next  = '0;
                        end
                    end else if (step_result == '0) begin
                        l_next = l_inc;
                        if (l_inc == TMAX) begin
                            state_next = ST_OVER;
                            hold_next  = '0;
                        end
                    end
                end
            end
            ST_OVER: begin
                if (!hold_done) begin
                    hold_next = hold_reg + 1'b1;
                end
`ifdef MM_AUTO_RESTART_EN
                if (hold_done) begin
                    state_next = ST_CLEAR;
                end
`else
                if (hold_done && init) begin
                    state_next = ST_CLEAR;
                end
`endif
            end
            ST_CLEAR: begin
                count_next = COUNT_INIT;
                w_next     = '0;
                l_next     = '0;
                hold_next  = '0;
                state_next = ST_PLAY;
            end
            default: begin
                state_next = ST_PLAY;
            end
        endcase
        // game_end mirrors the state we are entering, so it is high exactly
        // while the FSM sits in OVER.
        game_end_next = (state_next == ST_OVER);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge dclk) begin
        if (!arstn) begin
            state_reg    <= ST_PLAY;
            count_reg    <= COUNT_INIT;
            w_reg        <= '0;
            l_reg        <= '0;
            game_end_reg <= 1'b0;
            hold_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            w_reg        <= w_next;
            l_reg        <= l_next;
            game_end_reg <= game_end_next;
            hold_reg     <= hold_next;
        end
    end

    assign count    = count_reg;
    assign W_count  = w_reg;
    assign L_count  = l_reg;
    assign game_end = game_end_reg;

endmodule
